uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Captures the granted byte and pulses SEND to the transmitter, then waits for its completion pulse.
- Supports locked bursts, where one requester keeps the grant for up to MAX_BURST consecutive bytes.
- Runs a watchdog that aborts a hung frame.
- Sits between system byte producers (console, status, debug) and uart_tx.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- CLK_PARAM, 50000000: system clock in Hz.
- BAUD_RATE, 9600: line rate in bits per second.
- MAX_BURST, 16: maximum consecutive bytes under LOCK before forced rotation, 1..255.
- TIMEOUT_CYCLES, 12*(CLK_PARAM/BAUD_RATE): cycles allowed from launch to TX_DONE.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-requester byte-valid; held until ACK.
- REQ_DATA  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- LOCK  in  NUM_REQ  requester i asks to keep the grant after its current byte.
- ACK  out  NUM_REQ  one-hot 1-cycle pulse: byte of requester i captured.
- GRANT  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- TX_SEND  out  1  1-cycle start pulse to uart_tx.
- TX_DATA  out  8  byte to uart_tx; stable from TX_SEND until TX_DONE or abort.
- TX_DONE  in  1  1-cycle pulse from uart_tx after the stop bit.
- TX_ABORT  out  1  1-cycle pulse: watchdog fired, transmitter must reset.
- ERR_TIMEOUT  out  1  sticky timeout flag.
- ERR_CLR  in  1  clears ERR_TIMEOUT.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; rr pointer=0; burst count=0; timer=0.
  - ACK=0, GRANT=0, TX_SEND=0, TX_DATA=8'h00, TX_ABORT=0, ERR_TIMEOUT=0, BUSY=0.
  - Reset mid-frame drops the frame silently: no ACK, no TX_ABORT.
- States: IDLE, LAUNCH, WAIT_DONE, ABORT.
- IDLE:
  - If any REQ is high, select the first set REQ bit searching from rr pointer upward with wrap.
  - Next edge: state=LAUNCH; GRANT=onehot(sel); TX_DATA=REQ_DATA[sel]; burst count=1.
- LAUNCH (exactly 1 cycle):
  - TX_SEND=1 and ACK[sel]=1 in this cycle; timer cleared.
  - Next state WAIT_DONE.
  - Latency: REQ sampled high at edge N gives TX_SEND/ACK high in cycle N+1.
- WAIT_DONE:
  - Timer increments each cycle; TX_DATA and GRANT held.
  - On TX_DONE with LOCK[g] && REQ[g] && burst<MAX_BURST:
    - reload TX_DATA=REQ_DATA[g]; burst count++; state=LAUNCH; GRANT unchanged.
  - On TX_DONE otherwise:
    - rr pointer=(g+1) mod NUM_REQ; GRANT=0; burst count=0; state=IDLE.
  - On timer==TIMEOUT_CYCLES-1 without TX_DONE:
    - state=ABORT.
  - TX_DONE and timeout in the same cycle: TX_DONE wins, no error.
- ABORT (1 cycle):
  - TX_ABORT=1; ERR_TIMEOUT set.
  - rr pointer advanced past g; GRANT=0; state=IDLE.
  - The aborted byte has already been ACKed and is not retried.
- ERR_CLR:
  - Clears ERR_TIMEOUT unless ABORT is setting it in the same cycle; set wins.
- TX_DONE outside WAIT_DONE: ignored.
- REQ deasserted before ACK: legal; arbitration re-evaluates in IDLE each cycle.
- LOCK deasserted mid-burst: takes effect at the next TX_DONE.
- Burst reaching MAX_BURST: forced rotation even if LOCK is held.
  - If only that requester is asking, it is re-granted from IDLE one cycle later.
- Round-robin guarantee: with all REQ high and no LOCK, the grant order from reset is 0,1,2,3,0,...
- Minimum spacing between consecutive TX_SEND pulses: 2 cycles in a burst, 3 cycles otherwise.
- Widths:
  - timer: clog2(TIMEOUT_CYCLES) bits.
  - burst count: 8 bits.
  - rr pointer: clog2(NUM_REQ) bits, wraps modulo NUM_REQ.

Test Plan:
- Single byte:
  - Stimulus: REQ[2]=1, REQ_DATA byte2=8'hA5; TX_DONE returned 20 cycles after TX_SEND.
  - Required: one cycle after REQ, TX_SEND=1, ACK=4'b0100, TX_DATA=8'hA5, GRANT=4'b0100 until TX_DONE; then GRANT=0, BUSY=0.
- Round-robin fairness:
  - Stimulus: REQ=4'b1111 continuously, no LOCK, 8 frames.
  - Required: grant order 0,1,2,3,0,1,2,3, and ACK count per requester is 2.
- Locked burst:
  - Stimulus: MAX_BURST=3; REQ=4'b0011 with LOCK[0]=1.
  - Required: requester 0 gets 3 consecutive frames, then requester 1, then requester 0 again.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=100; TX_DONE never arrives.
  - Required: TX_ABORT pulses 101 cycles after TX_SEND; ERR_TIMEOUT=1 until ERR_CLR; next REQ is served normally.
- Simultaneous events:
  - TX_DONE in the cycle the timer expires: no TX_ABORT, ERR_TIMEOUT stays 0.
  - ERR_CLR in the same cycle as ABORT: ERR_TIMEOUT=1.
- Reset mid-frame:
  - Stimulus: drop RST_N during WAIT_DONE.
  - Required: all outputs are 0 immediately (asynchronous); after release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of a single uart_tx among NUM_REQ
// byte producers, with locked bursts and a per-frame completion watchdog.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int CLK_PARAM      = 50000000,
    parameter int BAUD_RATE      = 9600,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 12 * (CLK_PARAM / BAUD_RATE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_send,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 tx_abort,
    output logic                 err_timeout,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]         BURST_MAX  = 8'(MAX_BURST);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        ABORT     = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_reg, rr_next;
    logic [IDX_W-1:0]     owner_reg, owner_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [7:0]           burst_reg, burst_next;
    logic [7:0]           data_reg, data_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic                 err_reg, err_next;

    logic [7:0]           req_byte [NUM_REQ];
    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     rr_adv;
    int                   cand;

    // Unpack the flat request bus into one byte per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: first asserted request at or after the rr pointer, with wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_reg) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!sel_found && req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Pointer value that places the current owner last in the next search.
    assign rr_adv = (owner_reg == IDX_LAST) ? '0 : owner_reg + IDX_W'(1);

    // Next-state logic: arbitration, launch, completion wait and watchdog abort.
    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        owner_next = owner_reg;
        grant_next = grant_reg;
        burst_next = burst_reg;
        data_next  = data_reg;
        timer_next = timer_reg;
        err_next   = err_reg;
        if (err_clr) begin
            err_next = 1'b0;
        end
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next = LAUNCH;
                    owner_next = sel_idx;
                    grant_next = NUM_REQ'(1) << sel_idx;
                    data_next  = req_byte[sel_idx];
                    burst_next = 8'd1;
                end
            end
            LAUNCH: begin
                timer_next = '0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_next = timer_reg + TIMER_W'(1);
                if (tx_done) begin
                    if (lock[owner_reg] && req[owner_reg] && (burst_reg < BURST_MAX)) begin
                        data_next  = req_byte[owner_reg];
                        burst_next = burst_reg + 8'd1;
                        state_next = LAUNCH;
                    end else begin
                        rr_next    = rr_adv;
                        grant_next = '0;
                        burst_next = 8'd0;
                        state_next = IDLE;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = ABORT;
                end
            end
            ABORT: begin
                // Setting the flag here overrides a simultaneous clear.
                err_next   = 1'b1;
                rr_next    = rr_adv;
                grant_next = '0;
                burst_next = 8'd0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; reset drops any frame in flight without ACK or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            rr_reg    <= '0;
            owner_reg <= '0;
            grant_reg <= '0;
            burst_reg <= 8'd0;
            data_reg  <= 8'h00;
            timer_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            owner_reg <= owner_next;
            grant_reg <= grant_next;
            burst_reg <= burst_next;
            data_reg  <= data_next;
            timer_reg <= timer_next;
            err_reg   <= err_next;
        end
    end

    assign tx_send     = (state_reg == LAUNCH);
    assign ack         = (state_reg == LAUNCH) ? grant_reg : '0;
    assign grant       = grant_reg;
    assign tx_data     = data_reg;
    assign tx_abort    = (state_reg == ABORT);
    assign err_timeout = err_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level arbitration model
// predicts every frame, a monitor checks each TX_SEND and TX_ABORT.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 3;
    localparam int TO = 100;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         fate;   // -1: no TX_DONE (watchdog), else TX_DONE delay in cycles
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   lock = '0;
    logic           tx_done = 1'b0;
    logic           err_clr = 1'b0;
    logic [N-1:0]   ack, grant;
    logic           tx_send, tx_abort, err_timeout, busy;
    logic [7:0]     tx_data;

    int          vectors = 0;
    int          miscompares = 0;
    longint      cyc = 0;
    logic [7:0]  src_q [N][$];
    exp_t        exp_q [$];
    int          fate_q [$];
    int          order_q [$];
    int          ack_total [N];
    int          model_rr = 0;
    bit          ep_timeout = 0;
    int          done_cnt = 0;
    int          resp_fate;
    longint      abort_due = -1;
    exp_t        mon_e;

    uart_tx_arbiter #(
        .NUM_REQ(N), .CLK_PARAM(50000000), .BAUD_RATE(9600),
        .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .lock(lock),
        .ack(ack), .grant(grant), .tx_send(tx_send), .tx_data(tx_data),
        .tx_done(tx_done), .tx_abort(tx_abort), .err_timeout(err_timeout),
        .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Requesters present the head of their byte queue while it is non-empty.
    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req[i] = (src_q[i].size() > 0);
            req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
        end
    endtask

    function automatic int pick_fate(input int forced);
        int r;
        if (forced != 0) return forced;
        r = int'($urandom_range(0, 11));
        if (r == 0) return -1;
        if (r == 1) return TO;
        return int'($urandom_range(1, 12));
    endfunction

    // Reference model: walk the byte queues with round-robin + burst rules.
    task automatic schedule(input int forced);
        logic [7:0] mq [N][$];
        int   ptr, g, burst, f;
        bit   more, cont;
        exp_t e;
        for (int i = 0; i < N; i++) mq[i] = src_q[i];
        ptr  = model_rr;
        more = 1'b1;
        while (more) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && mq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
            end
            if (g < 0) begin
                more = 1'b0;
            end else begin
                burst = 0;
                do begin
                    f = pick_fate(forced);
                    e.idx  = g;
                    e.data = mq[g].pop_front();
                    e.fate = f;
                    exp_q.push_back(e);
                    fate_q.push_back(f);
                    if (f < 0) ep_timeout = 1'b1;
                    burst++;
                    cont = (f >= 0) && lock[g] && (mq[g].size() > 0) && (burst < MB);
                end while (cont);
                ptr = (g + 1) % N;
            end
        end
        model_rr = ptr;
    endtask

    task automatic start_episode(input int forced);
        schedule(forced);
        drive_reqs();
    endtask

    task automatic finish_episode(input string tag);
        int budget = 6000;
        while ((exp_q.size() > 0 || busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain: %0d frames still expected, required 0", tag, exp_q.size());
            exp_q.delete();
            fate_q.delete();
        end
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'(ep_timeout));
        if (ep_timeout) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check({tag, "_err_clr"}, 32'(err_timeout), 32'd0);
        end
        ep_timeout = 1'b0;
    endtask

    task automatic check_order(input string name, input int want[$]);
        check({name, "_count"}, 32'(order_q.size()), 32'(want.size()));
        for (int k = 0; k < want.size(); k++) begin
            if (k < order_q.size()) check(name, 32'(order_q[k]), 32'(want[k]));
        end
    endtask

    task automatic wait_send(input string tag);
        int budget = 50;
        while (!tx_send && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_send_seen"}, 32'(tx_send), 32'd1);
    endtask

    // Requester agents: retire the head byte once it is acknowledged.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            drive_reqs();
        end
    end

    // Transmitter stand-in: TX_DONE a scheduled number of cycles after TX_SEND.
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end
            if (tx_send) begin
                resp_fate = (fate_q.size() > 0) ? fate_q.pop_front() : -1;
                if (resp_fate > 0) done_cnt = resp_fate;
            end
        end
    end

    // Monitor: every launch is matched against the next predicted frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            abort_due = -1;
        end else begin
            if (tx_send) begin
                for (int i = 0; i < N; i++) if (grant[i]) order_q.push_back(i);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_send: grant %b data %h, required no launch", grant, tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("send: requester %0d data %h cycle %0d", mon_e.idx, mon_e.data, cyc);
                    check("ack", 32'(ack), 32'(1) << mon_e.idx);
                    check("grant", 32'(grant), 32'(1) << mon_e.idx);
                    check("tx_data", 32'(tx_data), 32'(mon_e.data));
                    check("busy_on_send", 32'(busy), 32'd1);
                    if (mon_e.fate < 0) abort_due = cyc + 101;
                    ack_total[mon_e.idx]++;
                end
            end else if (ack != '0) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_without_send: ack %b, required 0", ack);
            end
            if (tx_abort || cyc == abort_due) begin
                check("tx_abort_timing", 32'(tx_abort), 32'(cyc == abort_due));
                if (cyc == abort_due) abort_due = -1;
            end
        end
    end

    initial begin
        int want[$];
        int snap[N];

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_abort", 32'(tx_abort), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin fairness from reset: two bytes per requester, no lock.
        for (int i = 0; i < N; i++) begin
            src_q[i].push_back(8'($urandom));
            src_q[i].push_back(8'($urandom));
            snap[i] = ack_total[i];
        end
        lock = '0;
        order_q.delete();
        start_episode(4);
        finish_episode("rr");
        want = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("rr_order", want);
        for (int i = 0; i < N; i++) check("rr_ack_count", 32'(ack_total[i] - snap[i]), 32'd2);

        // Locked burst capped at MAX_BURST.
        for (int k = 0; k < 5; k++) src_q[0].push_back(8'($urandom));
        for (int k = 0; k < 2; k++) src_q[1].push_back(8'($urandom));
        lock = 4'b0001;
        order_q.delete();
        start_episode(3);
        finish_episode("burst");
        want = '{0, 0, 0, 1, 0, 0, 1};
        check_order("burst_order", want);
        lock = '0;

        // Single byte: launch one cycle after the request is sampled.
        src_q[2].push_back(8'hA5);
        start_episode(20);
        @(negedge clk);
        check("single_tx_send", 32'(tx_send), 32'd1);
        check("single_ack", 32'(ack), 32'b0100);
        check("single_tx_data", 32'(tx_data), 32'hA5);
        repeat (10) @(negedge clk);
        check("single_grant_held", 32'(grant), 32'b0100);
        check("single_data_held", 32'(tx_data), 32'hA5);
        finish_episode("single");

        // TX_DONE in the very cycle the watchdog would fire.
        src_q[3].push_back(8'($urandom));
        start_episode(TO);
        finish_episode("done_at_expiry");

        // Watchdog: no TX_DONE at all.
        src_q[1].push_back(8'($urandom));
        start_episode(-1);
        wait_send("wd");
        repeat (101) @(negedge clk);
        check("wd_abort_pulse", 32'(tx_abort), 32'd1);
        repeat (5) @(negedge clk);
        check("wd_err_sticky", 32'(err_timeout), 32'd1);
        finish_episode("wd");

        // ERR_CLR coinciding with the abort cycle: set wins.
        src_q[0].push_back(8'($urandom));
        start_episode(-1);
        wait_send("clr_race");
        repeat (101) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("clr_race_err", 32'(err_timeout), 32'd1);
        finish_episode("clr_race");

        // Reset in the middle of a frame.
        src_q[2].push_back(8'($urandom));
        src_q[3].push_back(8'($urandom));
        start_episode(50);
        wait_send("midrst");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_ack_send_abort", 32'({ack, tx_send, tx_abort}), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        fate_q.delete();
        model_rr = 0;
        ep_timeout = 1'b0;
        lock = '0;
        drive_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) src_q[i].push_back(8'($urandom));
        order_q.delete();
        start_episode(2);
        finish_episode("after_rst");
        want = '{0, 1, 2, 3};
        check_order("after_rst_order", want);

        // Randomised traffic with random locks, delays and watchdog aborts.
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < N; i++) begin
                int n = int'($urandom_range(0, 4));
                for (int k = 0; k < n; k++) src_q[i].push_back(8'($urandom));
                lock[i] = 1'($urandom_range(0, 1));
            end
            start_episode(0);
            finish_episode("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
